des_perm_unit: RTL and testbench

- Registered DES permutation engine. It applies one of three fixed FIPS 46-3 bit permutations to a 64-bit word:
  - Initial Permutation (IP)
  - Inverse Initial Permutation (IP^-1)
  - Expansion (E), 32->48
- Sits between the datapath staging registers and the round logic of an iterative DES core:
  - IP on block entry.
  - E inside each round's f-function.
  - IP^-1 on block exit.

---
 rtl/des_pkg.sv | 45 ++++
 rtl/des_bit_permute.sv | 16 +
 rtl/des_perm_unit.sv | 64 ++++++
 tb/tb_des_perm_unit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES permutation tables (FIPS 46-3, 1-based source bit indices) and mode encoding.
// Table entry i is the DES input bit that feeds DES output bit i+1.
package des_pkg;

   typedef enum logic [1:0] {
      PERM_IP     = 2'b00,
      PERM_IP_INV = 2'b01,
      PERM_E      = 2'b10,
      PERM_RSVD   = 2'b11
   } des_perm_mode_e;

   localparam int unsigned DES_IP [64] = '{
      58, 50, 42, 34, 26, 18, 10,  2,
      60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6,
      64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1,
      59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5,
      63, 55, 47, 39, 31, 23, 15,  7
   };

   localparam int unsigned DES_IP_INV [64] = '{
      40,  8, 48, 16, 56, 24, 64, 32,
      39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30,
      37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28,
      35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26,
      33,  1, 41,  9, 49, 17, 57, 25
   };

   localparam int unsigned DES_E [48] = '{
      32,  1,  2,  3,  4,  5,
       4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,
      12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,
      20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,
      28, 29, 30, 31, 32,  1
   };

endpackage

// File: rtl/des_bit_permute.sv
// Combinational table-driven bit permutation using DES MSB-first numbering:
// DES bit n of a W-bit word lives at word[W-n].
module des_bit_permute #(
   parameter int unsigned IN_W  = 64,
   parameter int unsigned OUT_W = 64,
   parameter int unsigned TBL [OUT_W] = '{default: 1}
) (
   input  logic [IN_W-1:0]  i_din,
   output logic [OUT_W-1:0] o_dout
);

   for (genvar g = 0; g < OUT_W; g++) begin : g_bit
      assign o_dout[OUT_W-1-g] = i_din[IN_W-TBL[g]];
   end

endmodule

// File: rtl/des_perm_unit.sv
// Registered DES permutation engine: IP, IP^-1 or E (32->48) selected per cycle,
// one-cycle latency, result held while no input is accepted.
module des_perm_unit
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [1:0]  mode,
   input  logic [63:0] din,
   output logic        out_valid,
   output logic [63:0] dout
);

   logic [63:0] w_ip_p0;
   logic [63:0] w_ip_inv_p0;
   logic [47:0] w_e_p0;
   logic [63:0] w_perm_p0;
   logic        r_vld_p1;
   logic [63:0] r_dout_p1;

   des_bit_permute #(.IN_W(64), .OUT_W(64), .TBL(DES_IP)) u_ip (
      .i_din  (din),
      .o_dout (w_ip_p0)
   );

   des_bit_permute #(.IN_W(64), .OUT_W(64), .TBL(DES_IP_INV)) u_ip_inv (
      .i_din  (din),
      .o_dout (w_ip_inv_p0)
   );

   // E sees only the low half-block; din[63:32] never reaches it.
   des_bit_permute #(.IN_W(32), .OUT_W(48), .TBL(DES_E)) u_e (
      .i_din  (din[31:0]),
      .o_dout (w_e_p0)
   );

   always_comb begin
      w_perm_p0 = '0;
      case (des_perm_mode_e'(mode))
         PERM_IP:     w_perm_p0 = w_ip_p0;
         PERM_IP_INV: w_perm_p0 = w_ip_inv_p0;
         PERM_E:      w_perm_p0 = {16'h0000, w_e_p0};
         default:     w_perm_p0 = '0;
      endcase
   end

   // p0 -> p1: reset wins over a simultaneous valid input
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld_p1  <= 1'b0;
         r_dout_p1 <= '0;
      end else begin
         r_vld_p1 <= in_valid;
         if (in_valid) begin
            r_dout_p1 <= w_perm_p0;
         end
      end
   end

   assign out_valid = r_vld_p1;
   assign dout      = r_dout_p1;

endmodule

// File: tb/tb_des_perm_unit.sv
// Directed checks of des_perm_unit against FIPS 46-3 known-answer vectors,
// plus a randomised IP -> IP^-1 streaming round trip with bubbles.
module tb_des_perm_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [1:0]  mode;
   logic [63:0] din;
   logic        out_valid;
   logic [63:0] dout;

   int checks = 0;
   int errors = 0;

   des_perm_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .mode      (mode),
      .din       (din),
      .out_valid (out_valid),
      .dout      (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [63:0] x;
      logic [63:0] ip_res;

      rst_n    = 1'b0;
      in_valid = 1'b1;
      mode     = 2'b00;
      din      = 64'h0123456789ABCDEF;

      // Reset held two cycles with a valid input present.
      cyc();
      chk("rst1_vld", {63'd0, out_valid}, 64'd0);
      chk("rst1_dout", dout, 64'd0);
      cyc();
      chk("rst2_vld", {63'd0, out_valid}, 64'd0);
      chk("rst2_dout", dout, 64'd0);

      rst_n = 1'b1;
      in_valid = 1'b1; mode = 2'b00; din = 64'h0123456789ABCDEF;
      cyc();
      chk("ip_vld", {63'd0, out_valid}, 64'd1);
      chk("ip_dout", dout, 64'hCC00CCFFF0AAF0AA);

      mode = 2'b10; din = 64'h00000000F0AAF0AA;
      cyc();
      chk("e_lo_vld", {63'd0, out_valid}, 64'd1);
      chk("e_lo_dout", dout, 64'h00007A15557A1555);

      din = 64'hFFFFFFFFF0AAF0AA;
      cyc();
      chk("e_hi_dout", dout, 64'h00007A15557A1555);

      mode = 2'b01; din = 64'h0A4CD99543423234;
      cyc();
      chk("ipinv_vld", {63'd0, out_valid}, 64'd1);
      chk("ipinv_dout", dout, 64'h85E813540F0AB405);

      // Bubble: junk operand must not disturb the held result.
      in_valid = 1'b0; mode = 2'b00; din = 64'hDEADBEEFCAFEF00D;
      cyc();
      chk("bub_vld", {63'd0, out_valid}, 64'd0);
      chk("bub_hold", dout, 64'h85E813540F0AB405);
      cyc();
      chk("bub2_hold", dout, 64'h85E813540F0AB405);

      in_valid = 1'b1; mode = 2'b11; din = 64'hFFFFFFFFFFFFFFFF;
      cyc();
      chk("rsvd_vld", {63'd0, out_valid}, 64'd1);
      chk("rsvd_dout", dout, 64'd0);

      // Reset coinciding with a valid IP input drops that input.
      mode = 2'b00; din = 64'h0123456789ABCDEF;
      cyc();
      chk("pre_rst_dout", dout, 64'hCC00CCFFF0AAF0AA);
      rst_n = 1'b0;
      cyc();
      chk("rstpri_vld", {63'd0, out_valid}, 64'd0);
      chk("rstpri_dout", dout, 64'd0);
      rst_n = 1'b1;
      cyc();
      chk("post_rst_vld", {63'd1, out_valid}, {63'd1, 1'b1});
      chk("post_rst_dout", dout, 64'hCC00CCFFF0AAF0AA);

      // Back-to-back mode changes on consecutive cycles.
      mode = 2'b10; din = 64'h00000000F0AAF0AA;
      cyc();
      chk("b2b_e", dout, 64'h00007A15557A1555);
      mode = 2'b01; din = 64'hCC00CCFFF0AAF0AA;
      cyc();
      chk("b2b_ipinv", dout, 64'h0123456789ABCDEF);

      // Streaming round trip with periodic bubbles.
      for (int i = 0; i < 100; i++) begin
         x = {$urandom, $urandom};
         in_valid = 1'b1; mode = 2'b00; din = x;
         cyc();
         chk("rt_ip_vld", {63'd0, out_valid}, 64'd1);
         ip_res = dout;
         mode = 2'b01; din = ip_res;
         cyc();
         chk("rt_vld", {63'd0, out_valid}, 64'd1);
         chk("rt_roundtrip", dout, x);
         if (i % 3 == 0) begin
            in_valid = 1'b0; mode = 2'(i); din = {$urandom, $urandom};
            cyc();
            chk("rt_bub_vld", {63'd0, out_valid}, 64'd0);
            chk("rt_bub_hold", dout, x);
         end
      end

      in_valid = 1'b0;
      cyc();
      chk("end_vld", {63'd0, out_valid}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
